// File: rtl/merge_out_writer_pkg.sv
// Shared constants for the merge-tree output writer: default geometry, byte sizes and FSM encodings.
package merge_out_writer_pkg;

    localparam int DEF_DATA_WIDTH = 128;
    localparam int DEF_P          = 8;
    localparam int DEF_DEPTH      = 16;
    localparam int DEF_BURST_LEN  = 8;
    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_CNT_WIDTH  = 32;

    localparam int BEAT_BYTES  = DEF_P * DEF_DATA_WIDTH / 8;
    localparam int BURST_BYTES = DEF_BURST_LEN * BEAT_BYTES;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_BURST = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/merge_out_fifo.sv
// Beat buffer between the merger root and the memory port: registered head, no bypass,
// push into a full buffer is allowed when a pop happens in the same cycle.
module merge_out_fifo #(
    parameter int WIDTH = 1024,
    parameter int DEPTH = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_data,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    assign o_full  = (count_q == (AW+1)'(DEPTH));
    assign o_empty = (count_q == '0);
    assign o_count = count_q;
    assign o_data  = mem_q[rd_q];

    assign pop_ok  = i_pop & ~o_empty;
    assign push_ok = i_push & (~o_full | pop_ok);

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (push_ok) wr_d = wr_q + AW'(1);
        if (pop_ok)  rd_d = rd_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage is deliberately left unreset; the pointers alone define what is valid.
    always_ff @(posedge i_clk) begin
        if (push_ok) mem_q[wr_q] <= i_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/merge_out_writer.sv
// Buffers merger-root beats and drains them as fixed-length address-tagged memory bursts.
// Optional sortedness checker enabled by defining MERGE_OUT_WRITER_SORTCHECK_EN.
module merge_out_writer
    import merge_out_writer_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int P          = DEF_P,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int BURST_LEN  = DEF_BURST_LEN,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    input  logic [ADDR_WIDTH-1:0]   i_base_addr,
    input  logic [CNT_WIDTH-1:0]    i_num_beats,
    input  logic [P*DATA_WIDTH-1:0] i_data,
    input  logic                    i_write,
    output logic                    o_ready,
    output logic [ADDR_WIDTH-1:0]   o_mem_addr,
    output logic [P*DATA_WIDTH-1:0] o_mem_data,
    output logic                    o_mem_valid,
    output logic                    o_mem_last,
    input  logic                    i_mem_ready,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_sort_err
);
    localparam int W     = P * DATA_WIDTH;
    localparam int OCC_W = $clog2(DEPTH) + 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(BURST_LEN * P * DATA_WIDTH / 8);
    localparam logic [CNT_WIDTH-1:0]  BL_C      = CNT_WIDTH'(BURST_LEN);

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_WIDTH-1:0]  num_q, num_d, rx_q, rx_d, tx_q, tx_d;
    logic [CNT_WIDTH-1:0]  bib_q, bib_d, need_q, need_d;
    logic [CNT_WIDTH-1:0]  remaining, need, occ_ext;
    logic [W-1:0]          head;
    logic [OCC_W-1:0]      occ;
    logic                  full, empty, push, pop, last_beat, accepting, start_ok;

    merge_out_fifo #(.WIDTH(W), .DEPTH(DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (push),
        .i_pop   (pop),
        .i_data  (i_data),
        .o_data  (head),
        .o_full  (full),
        .o_empty (empty),
        .o_count (occ)
    );

    assign accepting   = (state_q == ST_WAIT) || (state_q == ST_BURST);
    assign start_ok    = i_start && (state_q == ST_IDLE);
    assign o_mem_valid = (state_q == ST_BURST) && !empty;
    assign pop         = o_mem_valid & i_mem_ready;
    assign o_ready     = accepting && (rx_q != num_q) && (!full || pop);
    assign push        = i_write & o_ready;
    assign last_beat   = o_mem_valid && (bib_q == need_q - CNT_WIDTH'(1));
    assign o_mem_last  = last_beat;
    assign o_mem_data  = o_mem_valid ? head : '0;
    assign o_mem_addr  = addr_q;
    assign o_busy      = (state_q != ST_IDLE);
    assign o_done      = (state_q == ST_DONE);

    assign remaining = num_q - tx_q;
    assign need      = (remaining < BL_C) ? remaining : BL_C;
    assign occ_ext   = {{(CNT_WIDTH-OCC_W){1'b0}}, occ};

    // Burst length is frozen on entry so the shrinking remaining count cannot move the last beat.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        num_d   = num_q;
        rx_d    = push ? rx_q + CNT_WIDTH'(1) : rx_q;
        tx_d    = tx_q;
        bib_d   = bib_q;
        need_d  = need_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    num_d   = i_num_beats;
                    addr_d  = i_base_addr;
                    rx_d    = '0;
                    tx_d    = '0;
                    bib_d   = '0;
                    state_d = (i_num_beats == '0) ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (occ_ext >= need) begin
                    need_d  = need;
                    bib_d   = '0;
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                if (pop) begin
                    tx_d  = tx_q + CNT_WIDTH'(1);
                    bib_d = bib_q + CNT_WIDTH'(1);
                    if (last_beat) begin
                        addr_d  = addr_q + ADDR_STEP;
                        state_d = (tx_q + CNT_WIDTH'(1) == num_q) ? ST_DONE : ST_WAIT;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            num_q   <= '0;
            rx_q    <= '0;
            tx_q    <= '0;
            bib_q   <= '0;
            need_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            num_q   <= num_d;
            rx_q    <= rx_d;
            tx_q    <= tx_d;
            bib_q   <= bib_d;
            need_q  <= need_d;
        end
    end

`ifdef MERGE_OUT_WRITER_SORTCHECK_EN
    logic [DATA_WIDTH-1:0] prev_q, prev_d;
    logic                  err_q, err_d, viol;

    // The last record of each accepted beat is carried forward so ordering is checked across beats.
    always_comb begin
        viol = (i_data[DATA_WIDTH-1:0] < prev_q);
        for (int i = 1; i < P; i++) begin
            if (i_data[i*DATA_WIDTH +: DATA_WIDTH] < i_data[(i-1)*DATA_WIDTH +: DATA_WIDTH]) viol = 1'b1;
        end
        prev_d = prev_q;
        err_d  = err_q;
        if (start_ok) begin
            prev_d = '0;
            err_d  = 1'b0;
        end else if (push) begin
            prev_d = i_data[(P-1)*DATA_WIDTH +: DATA_WIDTH];
            err_d  = err_q | viol;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prev_q <= '0;
            err_q  <= 1'b0;
        end else begin
            prev_q <= prev_d;
            err_q  <= err_d;
        end
    end

    assign o_sort_err = err_q;
`else
    logic unused_start;
    assign unused_start = start_ok;
    assign o_sort_err   = 1'b0;
`endif

    a_write_when_ready: assert property (@(posedge i_clk) disable iff (!i_rst_n) i_write |-> o_ready);

endmodule

// File: tb/tb_merge_out_writer.sv
// Randomised bench for merge_out_writer: a queue scoreboard predicts every memory beat,
// address, last flag, completion pulse and sortedness flag from the transfer rules.
module tb_merge_out_writer;
    localparam int DW = 128;
    localparam int P  = 8;
    localparam int W  = P * DW;
    localparam int BL = 8;
    localparam int BURST_BYTES = 1024;

    logic          clk = 1'b0;
    logic          i_rst_n, i_start, i_write, i_mem_ready;
    logic [31:0]   i_base_addr, i_num_beats;
    logic [W-1:0]  i_data;
    logic          o_ready, o_mem_valid, o_mem_last, o_busy, o_done, o_sort_err;
    logic [31:0]   o_mem_addr;
    logic [W-1:0]  o_mem_data;

    int errors = 0;
    int checks = 0;

    logic [W-1:0]  pushed_q[$];
    logic [W-1:0]  obs_data[$];
    logic [31:0]   obs_addr[$];
    bit            obs_last[$];
    int            obs_cyc[$];
    int            done_cnt, done_cyc, hold_viol, ready_over, ready_low, full_pp, max_occ;
    bit            have_prev;
    logic [W-1:0]  prev_data;
    logic [31:0]   prev_addr;
    logic          prev_last;

    always #5 clk = ~clk;

    merge_out_writer dut (
        .i_clk       (clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_start),
        .i_base_addr (i_base_addr),
        .i_num_beats (i_num_beats),
        .i_data      (i_data),
        .i_write     (i_write),
        .o_ready     (o_ready),
        .o_mem_addr  (o_mem_addr),
        .o_mem_data  (o_mem_data),
        .o_mem_valid (o_mem_valid),
        .o_mem_last  (o_mem_last),
        .i_mem_ready (i_mem_ready),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_sort_err  (o_sort_err)
    );

    function automatic logic [W-1:0] gen_beat(input int mode, input int k);
        logic [W-1:0] b;
        b = '0;
        if (mode == 0) begin
            for (int w = 0; w < W/32; w++) b[w*32 +: 32] = $urandom;
        end else begin
            for (int i = 0; i < P; i++) begin
                if (k == 0)      b[i*DW +: DW] = DW'(5 + 2*i);
                else if (i == 0) b[i*DW +: DW] = DW'(3);
                else             b[i*DW +: DW] = DW'(100 + i);
            end
        end
        return b;
    endfunction

    // Sortedness predicted over the whole pushed record stream as one flat sequence.
    function automatic bit sort_model();
        logic [DW-1:0] prev;
        bit err;
        prev = '0;
        err  = 0;
        foreach (pushed_q[k]) begin
            for (int i = 0; i < P; i++) begin
                if (pushed_q[k][i*DW +: DW] < prev) err = 1;
                prev = pushed_q[k][i*DW +: DW];
            end
        end
        return err;
    endfunction

    function automatic bit exp_sort_err();
`ifdef MERGE_OUT_WRITER_SORTCHECK_EN
        return sort_model();
`else
        return 1'b0;
`endif
    endfunction

    // Counts beats whose data, address or last flag disagree with the scoreboard prediction.
    function automatic int stream_mismatches(input int n, input logic [31:0] base);
        int bad;
        logic [31:0] ea;
        bit el;
        bad = 0;
        if (obs_data.size() != n || pushed_q.size() != n) return 1000;
        for (int k = 0; k < n; k++) begin
            ea = base + 32'((k / BL) * BURST_BYTES);
            el = ((k % BL) == BL-1) || (k == n-1);
            if (obs_data[k] !== pushed_q[k] || obs_addr[k] !== ea || obs_last[k] !== el) bad++;
        end
        return bad;
    endfunction

    task automatic applyStimulus(input int n, input logic [31:0] base, input int stall,
                                 input bit rnd, input int abort_at, input int mode);
        int  idle_after, occ_pre;
        bit  popping, want;
        pushed_q.delete(); obs_data.delete(); obs_addr.delete(); obs_last.delete(); obs_cyc.delete();
        done_cnt = 0; done_cyc = -1; hold_viol = 0; ready_over = 0; ready_low = 0;
        full_pp = 0; max_occ = 0; have_prev = 0; idle_after = 0;
        @(negedge clk);
        i_start = 1'b1; i_base_addr = base; i_num_beats = 32'(n); i_write = 1'b0; i_mem_ready = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        for (int cyc = 1; cyc < 4000; cyc++) begin
            if (abort_at >= 0 && obs_data.size() == abort_at) begin
                i_write = 1'b0;
                i_mem_ready = 1'b0;
                return;
            end
            i_mem_ready = (cyc <= stall) ? 1'b0 : (rnd ? ($urandom_range(3) != 0) : 1'b1);
            #1;
            occ_pre = pushed_q.size() - obs_data.size();
            popping = o_mem_valid && i_mem_ready;
            if (have_prev && (!o_mem_valid || o_mem_data !== prev_data ||
                              o_mem_addr !== prev_addr || o_mem_last !== prev_last)) hold_viol++;
            have_prev = o_mem_valid && !i_mem_ready;
            prev_data = o_mem_data; prev_addr = o_mem_addr; prev_last = o_mem_last;
            if (popping) begin
                obs_data.push_back(o_mem_data);
                obs_addr.push_back(o_mem_addr);
                obs_last.push_back(o_mem_last);
                obs_cyc.push_back(cyc);
            end
            if (o_done) begin done_cnt++; done_cyc = cyc; end
            if (o_ready && pushed_q.size() == n) ready_over++;
            if (!o_ready && o_busy && pushed_q.size() < n) ready_low++;
            want = (pushed_q.size() < n) && (!rnd || $urandom_range(3) != 0);
            if (want && o_ready) begin
                if (occ_pre == 16 && popping) full_pp++;
                i_data  = gen_beat(mode, pushed_q.size());
                i_write = 1'b1;
                pushed_q.push_back(i_data);
            end else begin
                i_write = 1'b0;
            end
            if (pushed_q.size() - obs_data.size() > max_occ) max_occ = pushed_q.size() - obs_data.size();
            if (done_cnt > 0) idle_after++;
            if (idle_after > 3) break;
            @(negedge clk);
        end
        i_write = 1'b0;
        i_mem_ready = 1'b1;
    endtask

    task automatic checkOutput(input string name, input int n, input logic [31:0] base);
        int mm, last_cyc;
        checks++; mm = stream_mismatches(n, base);
        if (mm !== 0) begin errors++; $display("[TB] FAIL %s stream: mismatches=%0d pops=%0d pushes=%0d required n=%0d", name, mm, obs_data.size(), pushed_q.size(), n); end
        checks++;
        if (done_cnt !== 1) begin errors++; $display("[TB] FAIL %s done_count: got %0d required 1", name, done_cnt); end
        last_cyc = (obs_cyc.size() > 0) ? obs_cyc[obs_cyc.size()-1] : 0;
        checks++;
        if (done_cyc !== last_cyc + 1) begin errors++; $display("[TB] FAIL %s done_timing: got cycle %0d required %0d", name, done_cyc, last_cyc + 1); end
        checks++;
        if (hold_viol !== 0 || ready_over !== 0) begin errors++; $display("[TB] FAIL %s handshake: hold_viol=%0d ready_over=%0d required 0/0", name, hold_viol, ready_over); end
        checks++;
        if (o_busy !== 1'b0) begin errors++; $display("[TB] FAIL %s busy_after: got %b required 0", name, o_busy); end
        checks++;
        if (o_sort_err !== exp_sort_err()) begin errors++; $display("[TB] FAIL %s sort_err: got %b required %b", name, o_sort_err, exp_sort_err()); end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({o_ready, o_mem_valid, o_mem_last, o_busy, o_done, o_sort_err} !== 6'b0) begin
            errors++; $display("[TB] FAIL reset_flags: got %b required 000000", {o_ready, o_mem_valid, o_mem_last, o_busy, o_done, o_sort_err});
        end
        checks++;
        if (o_mem_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_addr: got %h required 0", o_mem_addr); end
        checks++;
        if (o_mem_data !== '0) begin errors++; $display("[TB] FAIL reset_data: got nonzero required 0"); end
    endtask

    task automatic test_burst16();
        applyStimulus(16, 32'h1000, 0, 1'b0, -1, 0);
        checkOutput("burst16", 16, 32'h1000);
    endtask

    task automatic test_short11();
        applyStimulus(11, 32'h2000, 0, 1'b0, -1, 0);
        checkOutput("short11", 11, 32'h2000);
    endtask

    task automatic test_backpressure();
        applyStimulus(40, 32'h0004_0000, 20, 1'b0, -1, 0);
        checkOutput("backpressure", 40, 32'h0004_0000);
        checks++;
        if (max_occ !== 16) begin errors++; $display("[TB] FAIL bp_fill: max occupancy %0d required 16", max_occ); end
        checks++;
        if (ready_low == 0 || full_pp == 0) begin errors++; $display("[TB] FAIL bp_ready: ready_low=%0d full_push_pop=%0d required both >0", ready_low, full_pp); end
    endtask

    task automatic test_random_wrap();
        applyStimulus(37, 32'hFFFF_F800, 0, 1'b1, -1, 0);
        checkOutput("random_wrap", 37, 32'hFFFF_F800);
    endtask

    task automatic test_zero();
        applyStimulus(0, 32'h3000, 0, 1'b0, -1, 0);
        checkOutput("zero", 0, 32'h3000);
        checks++;
        if (done_cyc !== 1) begin errors++; $display("[TB] FAIL zero_done: got cycle %0d required 1", done_cyc); end
    endtask

    task automatic test_reset_mid();
        applyStimulus(16, 32'h5000, 0, 1'b0, 4, 0);
        i_rst_n = 1'b0;
        #1;
        checks++;
        if ({o_ready, o_mem_valid, o_mem_last, o_busy, o_done, o_sort_err} !== 6'b0 || o_mem_addr !== 32'h0 || o_mem_data !== '0) begin
            errors++; $display("[TB] FAIL reset_mid: flags=%b addr=%h required 000000/0", {o_ready, o_mem_valid, o_mem_last, o_busy, o_done, o_sort_err}, o_mem_addr);
        end
        @(negedge clk);
        i_rst_n = 1'b1;
        applyStimulus(8, 32'h8000, 0, 1'b1, -1, 0);
        checkOutput("after_reset", 8, 32'h8000);
    endtask

    task automatic test_sortcheck();
        applyStimulus(2, 32'h9000, 0, 1'b0, -1, 1);
        checkOutput("sortcheck", 2, 32'h9000);
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if (o_sort_err !== exp_sort_err()) begin errors++; $display("[TB] FAIL sort_sticky: got %b required %b", o_sort_err, exp_sort_err()); end
    endtask

    initial begin
        i_rst_n = 1'b0; i_start = 1'b0; i_write = 1'b0; i_mem_ready = 1'b0;
        i_base_addr = '0; i_num_beats = '0; i_data = '0;
        repeat (2) @(negedge clk);
        test_reset();
        @(negedge clk);
        i_rst_n = 1'b1;
        test_burst16();
        test_short11();
        test_backpressure();
        test_random_wrap();
        test_zero();
        test_reset_mid();
        test_sortcheck();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
